// File: rtl/shift_scheduler_pkg.sv
// Shared types and constants for the two-requester iterative shift scheduler.
// Holds the FSM encoding, control-bit encodings and the fill-bit helper.
package shift_sched_pkg;

  localparam int WIDTH_DEF   = 32;
  localparam int SHAMT_W_DEF = $clog2(WIDTH_DEF);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic CTL0_LOGICAL = 1'b1;
  localparam logic CTL0_ARITH   = 1'b0;
  localparam logic CTL1_RIGHT   = 1'b1;
  localparam logic CTL1_LEFT    = 1'b0;

  // Only an arithmetic right shift replicates the sign bit into vacated MSBs.
  function automatic logic fill_bit(input logic ctl0, input logic ctl1, input logic msb);
    return ((ctl1 == CTL1_RIGHT) && (ctl0 == CTL0_ARITH)) ? msb : 1'b0;
  endfunction

endpackage

// File: rtl/shift_scheduler_if.sv
// Request/response bundle between the two requesters, the scheduler and the consumer.
// master = requesters + consumer side, slave = scheduler side.
interface shift_scheduler_if #(
  parameter int WIDTH = 32
);
  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic             req0_ctl0;
  logic             req0_ctl1;

  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic             req1_ctl0;
  logic             req1_ctl1;

  logic             resp_valid;
  logic             resp_ready;
  logic [WIDTH-1:0] resp_out;
  logic             resp_id;

  modport master (
    output req0_valid, req0_a, req0_b, req0_ctl0, req0_ctl1,
    input  req0_ready,
    output req1_valid, req1_a, req1_b, req1_ctl0, req1_ctl1,
    input  req1_ready,
    input  resp_valid, resp_out, resp_id,
    output resp_ready
  );

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_ctl0, req0_ctl1,
    output req0_ready,
    input  req1_valid, req1_a, req1_b, req1_ctl0, req1_ctl1,
    output req1_ready,
    output resp_valid, resp_out, resp_id,
    input  resp_ready
  );
endinterface

// File: rtl/shift_scheduler_stage.sv
// One combinational layer of the log shifter: shifts by 2^stage_idx when enabled.
// Right shifts insert the fill bit; left shifts insert zeros.
module shift_stage
  import shift_sched_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 3
) (
  input  logic [WIDTH-1:0] data_in,
  input  logic [CNT_W-1:0] stage_idx,
  input  logic             en,
  input  logic             dir,
  input  logic             fill,
  output logic [WIDTH-1:0] data_out
);

  int unsigned      dist_s;
  logic [WIDTH-1:0] fill_mask_s;

  // Select the shifted or pass-through value for this layer.
  always_comb begin
    dist_s      = 32'd1 << stage_idx;
    fill_mask_s = ~({WIDTH{1'b1}} >> dist_s);
    data_out    = data_in;
    if (!en) begin
      data_out = data_in;
    end else if (dir == CTL1_RIGHT) begin
      data_out = (data_in >> dist_s) | (fill ? fill_mask_s : {WIDTH{1'b0}});
    end else begin
      data_out = data_in << dist_s;
    end
  end

endmodule

// File: rtl/shift_scheduler.sv
// Round-robin front end that accepts one op at a time and runs it through a
// single reused shift layer, one power-of-two stage per clock.
module shift_scheduler
  import shift_sched_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  shift_scheduler_if.slave  bus
);

  localparam int CNT_W = (SHAMT_W > 1) ? $clog2(SHAMT_W) : 1;

  state_t             state_r;
  state_t             state_nxt_s;
  logic [CNT_W-1:0]   cnt_r;
  logic [WIDTH-1:0]   data_r;
  logic [SHAMT_W-1:0] shamt_r;
  logic               dir_r;
  logic               fill_r;
  logic               id_r;
  logic               ptr_r;
  logic               resp_valid_r;
  logic [WIDTH-1:0]   resp_out_r;
  logic               resp_id_r;

  logic               grant_id_s;
  logic               idle_s;
  logic               any_valid_s;
  logic               accept_s;
  logic               last_stage_s;
  logic [WIDTH-1:0]   sel_a_s;
  logic [WIDTH-1:0]   sel_b_s;
  logic               sel_ctl0_s;
  logic               sel_ctl1_s;
  logic [WIDTH-1:0]   stage_out_s;
  logic               unused_b_s;

  assign unused_b_s = ^{bus.req0_b[WIDTH-1:SHAMT_W], bus.req1_b[WIDTH-1:SHAMT_W]};

  // Arbitration: a lone requester wins; on contention the pointer decides.
  always_comb begin
    grant_id_s = 1'b0;
    if (bus.req0_valid && bus.req1_valid) begin
      grant_id_s = ptr_r;
    end else if (bus.req1_valid) begin
      grant_id_s = 1'b1;
    end else begin
      grant_id_s = 1'b0;
    end
  end

  assign idle_s       = (state_r == IDLE);
  assign any_valid_s  = bus.req0_valid | bus.req1_valid;
  assign accept_s     = idle_s & any_valid_s;
  assign last_stage_s = (cnt_r == CNT_W'(SHAMT_W - 1));

  // Ready is forced low while reset is held even though the state reads IDLE.
  assign bus.req0_ready = rst_n & idle_s & bus.req0_valid & ~grant_id_s;
  assign bus.req1_ready = rst_n & idle_s & bus.req1_valid & grant_id_s;

  assign sel_a_s    = grant_id_s ? bus.req1_a    : bus.req0_a;
  assign sel_b_s    = grant_id_s ? bus.req1_b    : bus.req0_b;
  assign sel_ctl0_s = grant_id_s ? bus.req1_ctl0 : bus.req0_ctl0;
  assign sel_ctl1_s = grant_id_s ? bus.req1_ctl1 : bus.req0_ctl1;

  shift_stage #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_stage (
    .data_in   (data_r),
    .stage_idx (cnt_r),
    .en        (shamt_r[cnt_r]),
    .dir       (dir_r),
    .fill      (fill_r),
    .data_out  (stage_out_s)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) state_nxt_s = SHIFT;
        else          state_nxt_s = IDLE;
      end
      SHIFT: begin
        if (last_stage_s) state_nxt_s = DONE;
        else              state_nxt_s = SHIFT;
      end
      DONE: begin
        if (bus.resp_ready) state_nxt_s = IDLE;
        else                state_nxt_s = DONE;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Operand capture, stage iteration and registered response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r        <= {CNT_W{1'b0}};
      data_r       <= {WIDTH{1'b0}};
      shamt_r      <= {SHAMT_W{1'b0}};
      dir_r        <= 1'b0;
      fill_r       <= 1'b0;
      id_r         <= 1'b0;
      ptr_r        <= 1'b0;
      resp_valid_r <= 1'b0;
      resp_out_r   <= {WIDTH{1'b0}};
      resp_id_r    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            data_r  <= sel_a_s;
            shamt_r <= sel_b_s[SHAMT_W-1:0];
            dir_r   <= sel_ctl1_s;
            fill_r  <= fill_bit(sel_ctl0_s, sel_ctl1_s, sel_a_s[WIDTH-1]);
            id_r    <= grant_id_s;
            cnt_r   <= {CNT_W{1'b0}};
            ptr_r   <= ~grant_id_s;
          end
        end
        SHIFT: begin
          data_r <= stage_out_s;
          cnt_r  <= cnt_r + CNT_W'(1);
          if (last_stage_s) begin
            resp_out_r   <= stage_out_s;
            resp_id_r    <= id_r;
            resp_valid_r <= 1'b1;
          end
        end
        DONE: begin
          if (bus.resp_ready) resp_valid_r <= 1'b0;
        end
        default: begin
          resp_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.resp_valid = resp_valid_r;
  assign bus.resp_out   = resp_out_r;
  assign bus.resp_id    = resp_id_r;

endmodule

// File: tb/tb_shift_scheduler.sv
// Randomized bench for shift_scheduler against a behavioural arbitration/shift model.
module tb_shift_scheduler;

  localparam int W = 32;
  localparam int S = 5;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  shift_scheduler_if #(.WIDTH(W)) bus ();

  shift_scheduler #(.WIDTH(W), .SHAMT_W(S)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic          tv  [2];
  logic [W-1:0]  ta  [2];
  logic [W-1:0]  tbv [2];
  logic          tc0 [2];
  logic          tc1 [2];
  logic          ptr_m;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] ref_shift(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic ctl0, input logic ctl1);
    int s;
    s = int'(b % W);
    if (!ctl1)     return a << s;
    else if (ctl0) return a >> s;
    else           return W'($signed(a) >>> s);
  endfunction

  task automatic set_req(input int i, input logic v, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic c0, input logic c1);
    tv[i] = v; ta[i] = a; tbv[i] = b; tc0[i] = c0; tc1[i] = c1;
  endtask

  task automatic drive_reqs();
    bus.req0_valid = tv[0]; bus.req0_a = ta[0]; bus.req0_b = tbv[0];
    bus.req0_ctl0  = tc0[0]; bus.req0_ctl1 = tc1[0];
    bus.req1_valid = tv[1]; bus.req1_a = ta[1]; bus.req1_b = tbv[1];
    bus.req1_ctl0  = tc0[1]; bus.req1_ctl1 = tc1[1];
  endtask

  task automatic noise();
    bus.req0_valid = 1'b1; bus.req0_a = $urandom; bus.req0_b = $urandom;
    bus.req0_ctl0  = 1'($urandom); bus.req0_ctl1 = 1'($urandom);
    bus.req1_valid = 1'b1; bus.req1_a = $urandom; bus.req1_b = $urandom;
    bus.req1_ctl0  = 1'($urandom); bus.req1_ctl1 = 1'($urandom);
  endtask

  task automatic rand_reqs();
    int sel;
    sel = int'($urandom_range(2, 0));
    for (int i = 0; i < 2; i++)
      set_req(i, 1'b0, $urandom, $urandom, 1'($urandom), 1'($urandom));
    if (sel == 0)      tv[0] = 1'b1;
    else if (sel == 1) tv[1] = 1'b1;
    else begin tv[0] = 1'b1; tv[1] = 1'b1; end
  endtask

  // Called just after a negedge with the DUT idle; returns just after a negedge, idle.
  task automatic run_op(input int hold);
    logic         g;
    logic [W-1:0] exp;
    drive_reqs();
    bus.resp_ready = 1'b0;
    g   = (tv[0] && tv[1]) ? ptr_m : tv[1];
    exp = ref_shift(ta[g], tbv[g], tc0[g], tc1[g]);
    #1;
    check("accept_ready0", W'(bus.req0_ready), W'(tv[0] && !g));
    check("accept_ready1", W'(bus.req1_ready), W'(tv[1] && g));
    @(posedge clk);
    ptr_m = ~g;
    for (int i = 0; i < S; i++) begin
      @(negedge clk);
      noise();
      #1;
      check("busy_valid", W'(bus.resp_valid), W'(0));
      check("busy_ready", W'({bus.req1_ready, bus.req0_ready}), W'(0));
      @(posedge clk);
    end
    @(negedge clk);
    check("done_valid", W'(bus.resp_valid), W'(1));
    check("done_out", bus.resp_out, exp);
    check("done_id", W'(bus.resp_id), W'(g));
    for (int h = 0; h < hold; h++) begin
      noise();
      #1;
      check("hold_ready", W'({bus.req1_ready, bus.req0_ready}), W'(0));
      @(posedge clk);
      @(negedge clk);
      check("hold_valid", W'(bus.resp_valid), W'(1));
      check("hold_out", bus.resp_out, exp);
      check("hold_id", W'(bus.resp_id), W'(g));
    end
    noise();
    bus.resp_ready = 1'b1;
    #1;
    check("hs_ready", W'({bus.req1_ready, bus.req0_ready}), W'(0));
    @(posedge clk);
    @(negedge clk);
    check("hs_valid_low", W'(bus.resp_valid), W'(0));
    bus.resp_ready = 1'b0;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    ptr_m    = 1'b0;
    rst_n    = 1'b0;
    bus.resp_ready = 1'b0;
    noise();
    #23;
    check("rst_ready", W'({bus.req1_ready, bus.req0_ready}), W'(0));
    check("rst_valid", W'(bus.resp_valid), W'(0));
    check("rst_out", bus.resp_out, W'(0));
    check("rst_id", W'(bus.resp_id), W'(0));
    @(negedge clk);
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    rst_n = 1'b1;

    // Directed ops.
    set_req(0, 1'b1, 32'h8000_0001, 32'd4, 1'b1, 1'b1);
    set_req(1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    run_op(0);
    set_req(0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    set_req(1, 1'b1, 32'h8000_0000, 32'd31, 1'b0, 1'b1);
    run_op(0);
    set_req(1, 1'b1, 32'h8000_0000, 32'd31, 1'b1, 1'b1);
    run_op(0);
    set_req(1, 1'b1, 32'h0000_000F, 32'h0000_0024, 1'b0, 1'b0);
    run_op(0);
    for (int k = 0; k < 4; k++) begin
      set_req(0, 1'b1, $urandom, $urandom, 1'($urandom), 1'($urandom));
      set_req(1, 1'b1, $urandom, $urandom, 1'($urandom), 1'($urandom));
      run_op((k == 1) ? 10 : 0);
    end

    // Reset in the middle of a shift.
    set_req(0, 1'b1, 32'h1234_5678, 32'd3, 1'b1, 1'b1);
    set_req(1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    drive_reqs();
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    noise();
    #1;
    check("midrst_ready", W'({bus.req1_ready, bus.req0_ready}), W'(0));
    check("midrst_out", bus.resp_out, W'(0));
    @(negedge clk);
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    rst_n = 1'b1;
    ptr_m = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("midrst_no_resp", W'(bus.resp_valid), W'(0));
    end
    set_req(0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    set_req(1, 1'b1, 32'hF000_0000, 32'd8, 1'b0, 1'b1);
    run_op(0);
    set_req(0, 1'b1, 32'h0000_00FF, 32'd1, 1'b0, 1'b0);
    set_req(1, 1'b1, 32'h0000_00FF, 32'd2, 1'b0, 1'b0);
    run_op(0);

    // Randomized traffic.
    for (int k = 0; k < 150; k++) begin
      rand_reqs();
      run_op(int'($urandom_range(3, 0)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/shift_scheduler.md
Name: shift_scheduler

Overview:
- Two-requester front end for the shifter datapath.
- Arbitrates between two requesters with round-robin priority and captures the winning operand and control bits.
- Sequences the shift as an iterative log shifter, applying one power-of-two stage per clock: stage k shifts by 2^k when B[k]=1.
- Returns the result over a valid/ready response channel tagged with the requester id.
- Sits between the ALU issue logic and the writeback path; replaces a full-width single-cycle barrel for area-constrained builds.

Parameters:
- WIDTH, 32, operand/result width.
- SHAMT_W, 5, shift-amount bits used (log2 WIDTH); stage count = SHAMT_W.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req0_valid  in  1  requester 0 has an op.
- req0_ready  out  1  requester 0 op accepted this cycle when valid&ready.
- req0_a  in  WIDTH  operand to shift.
- req0_b  in  WIDTH  shift amount; only bits [SHAMT_W-1:0] used.
- req0_ctl0  in  1  1=logical, 0=arithmetic.
- req0_ctl1  in  1  1=right, 0=left.
- req1_valid, req1_ready, req1_a, req1_b, req1_ctl0, req1_ctl1: same as requester 0, for requester 1.
- resp_valid  out  1  result available.
- resp_ready  in  1  consumer takes result.
- resp_out  out  WIDTH  shifted result.
- resp_id  out  1  requester that issued the op.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, stage counter=0, data reg=0, resp_valid=0, resp_out=0, resp_id=0.
  - Priority pointer=0 (requester 0 favoured).
  - req0_ready=req1_ready=0 while rst_n=0.
- States: IDLE, SHIFT, DONE.
- IDLE arbitration (combinational):
  - Grant goes to the only valid requester.
  - If both are valid, grant goes to the pointer's requester.
  - reqX_ready=1 only in IDLE and only for the granted X; ready never depends on the other requester's ready.
- Accept edge (valid&ready):
  - Capture a, b[SHAMT_W-1:0], ctl0, ctl1 and id.
  - Capture fill bit = (ctl1 & ~ctl0) ? a[WIDTH-1] : 0.
  - counter=0; pointer = ~granted id; go to SHIFT.
- SHIFT:
  - Each edge, data = stage(data, shamt[counter]); counter++.
  - stage k, shamt bit = 1, right: data >> 2^k, vacated MSBs = fill bit.
  - stage k, shamt bit = 1, left: data << 2^k, vacated LSBs = 0. Arithmetic-left equals logical-left.
  - stage k, shamt bit = 0: data unchanged.
  - After the edge that applies stage SHAMT_W-1, go to DONE.
  - Fixed latency, no early exit for shamt=0.
- DONE:
  - resp_valid=1; resp_out and resp_id are held stable until resp_ready.
  - Edge with resp_ready=1: go to IDLE, resp_valid=0.
  - No new accept in the same cycle as response handshake; the earliest next accept is the cycle after.
- Timing:
  - Accept at edge t0; resp_valid rises after edge t0+SHAMT_W (5).
  - Minimum op-to-op spacing is SHAMT_W+2 cycles.
- Request changes:
  - Requester inputs changing while not accepted are ignored; no state is affected.
  - A requester dropping valid before accept is legal.
- Reset mid-operation aborts the op. No response is produced and the pointer returns to 0.
- Starvation bound: a continuously valid requester is granted within 2 ops.

Decomposition:
- Package shift_sched_pkg:
  - state enum (IDLE, SHIFT, DONE).
  - ctl encodings: CTL0_LOGICAL=1, CTL0_ARITH=0, CTL1_RIGHT=1, CTL1_LEFT=0.
  - SHAMT_W derivation.
- Sub-module shift_stage: combinational single layer.
  - Inputs: data, stage index, enable bit, direction, fill.
  - Output: shifted data.
  - Instantiated once and indexed by counter.

Test Plan:
- Only req0_valid, a=0x80000001, b=4, ctl0=1, ctl1=1, resp_ready=1 -> req0_ready=1 at t0; resp_valid after edge t0+5; resp_out=0x08000000, resp_id=0.
- req1: a=0x80000000, b=31, ctl0=0, ctl1=1 -> resp_out=0xFFFFFFFF, id=1. Same op with ctl0=1 -> 0x00000001.
- Left shift: a=0x0000000F, b=0x00000024 (only low 5 bits used = 4), ctl0=0, ctl1=0 -> resp_out=0x000000F0 (arith-left same as logical).
- Both valid continuously, resp_ready=1 -> grants alternate 0,1,0,1; resp_id sequence matches.
- resp_ready held 0 for 10 cycles in DONE -> resp_valid, resp_out and resp_id stable; both readys stay 0; completes on first resp_ready=1.
- rst_n pulsed low during SHIFT (counter=2) -> resp_valid never asserts; state IDLE; next op from req1-only completes normally with pointer starting at 0.
